// File: rtl/rreq_sync_receiver_pkg.sv
// Shared constants and state encoding for the Rreq synchronizing receiver.
package rreq_sync_receiver_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

endpackage

// File: rtl/rreq_sync_fifo.sv
// Small show-ahead FIFO with occupancy count and registered full/empty flags.
module rreq_sync_fifo
  import rreq_sync_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // Overflowing pushes and underflowing pops are dropped here as a backstop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_c  = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, count and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rreq_sync_receiver.sv
// Clocked consumer of a 4-phase bundled-data channel: synchronizes rreq,
// captures rdata into a FIFO, returns rack and presents words as valid/ready.
module rreq_sync_receiver
  import rreq_sync_receiver_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rreq,
  input  logic [WIDTH-1:0]             rdata,
  output logic                         rack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  state_t                 state_q;
  state_t                 state_d;
  logic                   push_c;
  logic                   full;
  logic                   empty;

  // Multi-flop synchronizer; nothing looks at rreq ahead of this chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rreq};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Handshake state register; it drives rack directly.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // One capture per 4-phase cycle; rack is withheld while the FIFO is full.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && !full) begin
          push_c  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rack      = (state_q == S_ACK);
  assign out_valid = ~empty;

  // rdata is sampled raw: the bundling constraint keeps it stable through the sync delay.
  rreq_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_c),
    .pop    (out_valid & out_ready),
    .wdata  (rdata),
    .head_c (out_data),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

endmodule

// File: tb/tb_rreq_sync_receiver.sv
// Scoreboard bench for rreq_sync_receiver (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
module tb_rreq_sync_receiver;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         rreq;
  logic [W-1:0] rdata;
  logic         rack;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];
  int  mcount     = 0;
  bit  pop_pend   = 1'b0;
  bit  rack_prev  = 1'b0;
  bit  rst_prev   = 1'b1;
  bit  stream_mode = 1'b0;
  int  push_total = 0;
  int  simul      = 0;

  rreq_sync_receiver #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rreq      (rreq),
    .rdata     (rdata),
    .rack      (rack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Occupancy model, pop-side scoreboard compare, sampled mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] exp_word;
    if (rst_prev) begin
      mcount   = 0;
      pop_pend = 1'b0;
    end else begin
      if (rack && !rack_prev) begin
        push_total++;
        if (pop_pend) simul++;
        mcount++;
      end
      if (pop_pend) mcount--;
      pop_pend = 1'b0;
      check("count", 32'(count), 32'(mcount));
      check("out_valid", 32'(out_valid), 32'(mcount != 0));
      if (stream_mode) check("stream_count_le1", 32'(count <= 3'd1), 32'd1);
      if (!rst && out_ready && mcount > 0) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_word = sb.pop_front();
          check("out_data", 32'(out_data), 32'(exp_word));
        end
        pop_pend = 1'b1;
      end
    end
    rack_prev = rack;
    rst_prev  = rst;
  end

  // Wait (bounded) until rack reaches level; n = edges waited.
  task automatic wait_rack(input logic level, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rack !== level && n < 20);
    if (rack !== level) check("rack_timeout", 32'(rack), 32'(level));
  endtask

  task automatic handshake(input logic [W-1:0] d, input bit chk_lat);
    int n;
    rdata = d;
    rreq  = 1'b1;
    sb.push_back(d);
    wait_rack(1'b1, n);
    if (chk_lat) check("rack_rise_lat", 32'(n), 32'd3);
    rreq = 1'b0;
    wait_rack(1'b0, n);
    if (chk_lat) check("rack_fall_lat", 32'(n), 32'd3);
  endtask

  task automatic drain(input int cycles);
    out_ready = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("drained_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    int s0;
    bit done;
    rst = 1'b1; rreq = 1'b0; rdata = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_rack", 32'(rack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // Single handshake with latency checks.
    rdata = 8'hA5; rreq = 1'b1; sb.push_back(8'hA5);
    wait_rack(1'b1, n);
    check("single_rise_lat", 32'(n), 32'd3);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_count", 32'(count), 32'd1);
    rreq = 1'b0;
    wait_rack(1'b0, n);
    check("single_fall_lat", 32'(n), 32'd3);
    drain(2);

    // Burst into a full FIFO: 5th request is back-pressured.
    for (int i = 1; i <= 4; i++) handshake(8'(i), 1'b1);
    check("burst_full_count", 32'(count), 32'd4);
    rdata = 8'h05; rreq = 1'b1; sb.push_back(8'h05);
    repeat (6) begin @(posedge clk); #1; end
    check("burst_rack_held", 32'(rack), 32'd0);
    check("burst_count_held", 32'(count), 32'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("burst_rack_pop_edge", 32'(rack), 32'd0);
    check("burst_count_after_pop", 32'(count), 32'd3);
    @(posedge clk); #1;
    check("burst_rack_after_pop", 32'(rack), 32'd1);
    check("burst_count_refill", 32'(count), 32'd4);
    rreq = 1'b0;
    wait_rack(1'b0, n);
    drain(8);

    // Streaming: 10 back-to-back handshakes with out_ready held high.
    stream_mode = 1'b1;
    p0 = push_total;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) handshake(8'(32'h10 + i), 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("stream_pushes", 32'(push_total - p0), 32'd10);
    stream_mode = 1'b0;
    out_ready = 1'b0;
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Pointer wrap with interleaved pops, including same-edge push/pop.
    for (int i = 0; i < 3; i++) handshake(8'(32'h20 + i), 1'b0);
    s0 = simul;
    done = 1'b0;
    fork
      begin
        for (int i = 3; i < 9; i++) handshake(8'(32'h20 + i), 1'b0);
        done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!done) begin
          @(posedge clk); #1;
          cyc++;
          out_ready = (cyc % 5 == 0);
        end
        out_ready = 1'b0;
      end
    join
    check("wrap_simul_push_pop", 32'(simul > s0), 32'd1);
    drain(10);

    // Reset while in S_ACK with two words stored.
    handshake(8'h31, 1'b0);
    rdata = 8'h32; rreq = 1'b1; sb.push_back(8'h32);
    wait_rack(1'b1, n);
    check("mid_count", 32'(count), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rack", 32'(rack), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    sb.push_back(8'h32);
    rst = 1'b0;
    wait_rack(1'b1, n);
    check("recapture_lat", 32'(n), 32'd3);
    check("recapture_count", 32'(count), 32'd1);
    check("recapture_data", 32'(out_data), 32'h32);
    rreq = 1'b0;
    wait_rack(1'b0, n);
    drain(3);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
